// File: rtl/loga_pkg.sv
// Shared constants, state enums and helpers for the logic-analyser trigger unit.
package loga_pkg;

    localparam logic [2:0] TM_OFF  = 3'd0;
    localparam logic [2:0] TM_RISE = 3'd1;
    localparam logic [2:0] TM_FALL = 3'd2;
    localparam logic [2:0] TM_ANY  = 3'd3;
    localparam logic [2:0] TM_HIGH = 3'd4;
    localparam logic [2:0] TM_LOW  = 3'd5;
    localparam logic [2:0] TM_LAST = 3'd5;

    localparam logic [7:0] KEY_BRK  = 8'hF0;
    localparam logic [7:0] KEY_EXT  = 8'hE0;
    localparam logic [7:0] KEY_DOWN = 8'h72;
    localparam logic [7:0] KEY_UP   = 8'h75;
    localparam logic [7:0] KEY_TRIG = 8'h2C;
    localparam logic [7:0] KEY_COMB = 8'h21;
    localparam logic [7:0] KEY_CLR  = 8'h2D;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_EXT  = 2'd1,
        K_BRK  = 2'd2
    } key_state_e;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_ARMED = 2'd1,
        A_TRIG  = 2'd2
    } arm_state_e;

    // Wraps the last legal mode (and any unreachable code) back to off.
    function automatic logic [2:0] next_mode(input logic [2:0] m);
        return (m >= TM_LAST) ? TM_OFF : m + 3'd1;
    endfunction

endpackage

// File: rtl/loga_ps2_cmd.sv
// PS/2 byte decoder: only break codes (F0 or E0 F0 prefix) produce a command strobe.
module loga_ps2_cmd
    import loga_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] key_i,
    input  logic       key_valid_i,
    output logic       cmd_next_o,
    output logic       cmd_prev_o,
    output logic       cmd_mode_o,
    output logic       cmd_comb_o,
    output logic       cmd_clr_o
);

    key_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= K_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cmd_next_o = 1'b0;
        cmd_prev_o = 1'b0;
        cmd_mode_o = 1'b0;
        cmd_comb_o = 1'b0;
        cmd_clr_o  = 1'b0;
        if (key_valid_i) begin
            case (state_q)
                K_IDLE: begin
                    if (key_i == KEY_BRK)      state_d = K_BRK;
                    else if (key_i == KEY_EXT) state_d = K_EXT;
                    else                       state_d = K_IDLE;
                end
                K_EXT: state_d = (key_i == KEY_BRK) ? K_BRK : K_IDLE;
                K_BRK: begin
                    state_d    = K_IDLE;
                    cmd_next_o = (key_i == KEY_DOWN);
                    cmd_prev_o = (key_i == KEY_UP);
                    cmd_mode_o = (key_i == KEY_TRIG);
                    cmd_comb_o = (key_i == KEY_COMB);
                    cmd_clr_o  = (key_i == KEY_CLR);
                end
                default: state_d = K_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/loga_trig_unit.sv
// Trigger configuration registers, synchronised edge/level matcher and arm/fire FSM.
module loga_trig_unit
    import loga_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int CSEL_W = $clog2(CH_NUM)
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [7:0]          Key_IN,
    input  logic                Key_Valid,
    input  logic [CH_NUM-1:0]   Switch_IN,
    input  logic [CH_NUM-1:0]   CH_INPUT,
    input  logic                Arm,
    output logic [CSEL_W-1:0]   Ch_Sel,
    output logic [3*CH_NUM-1:0] Trig_Mode_OUT,
    output logic                Trig_Combine,
    output logic                Armed,
    output logic                Trig_Pulse,
    output logic [CH_NUM-1:0]   Trig_Chan
);

    logic cmd_next, cmd_prev, cmd_mode, cmd_comb, cmd_clr;

    loga_ps2_cmd u_ps2_cmd (
        .clk_i       (CLOCK),
        .rst_ni      (RESET),
        .key_i       (Key_IN),
        .key_valid_i (Key_Valid),
        .cmd_next_o  (cmd_next),
        .cmd_prev_o  (cmd_prev),
        .cmd_mode_o  (cmd_mode),
        .cmd_comb_o  (cmd_comb),
        .cmd_clr_o   (cmd_clr)
    );

    logic [CSEL_W-1:0]      sel_q, sel_d;
    logic [CH_NUM-1:0][2:0] mode_q, mode_d;
    logic                   comb_q, comb_d;
    logic [CH_NUM-1:0]      sync1_q, samp_q, hist_q;
    arm_state_e             arm_q, arm_d;
    logic                   blank_q, blank_d;
    logic                   pulse_q, pulse_d;
    logic [CH_NUM-1:0]      chan_q, chan_d;
    logic [CH_NUM-1:0]      active, match;
    logic                   fire;
    logic                   cfg_lock;

    // Mode, combine and clear edits are frozen while a capture is pending.
    assign cfg_lock = (arm_q == A_ARMED);

    always_comb begin
        sel_d  = sel_q;
        mode_d = mode_q;
        comb_d = comb_q;
        if (cmd_next)
            sel_d = (sel_q == CSEL_W'(CH_NUM-1)) ? '0 : sel_q + CSEL_W'(1);
        else if (cmd_prev)
            sel_d = (sel_q == '0) ? CSEL_W'(CH_NUM-1) : sel_q - CSEL_W'(1);
        if (!cfg_lock) begin
            if (cmd_clr)
                mode_d = '0;
            else if (cmd_mode && Switch_IN[sel_q])
                mode_d[sel_q] = next_mode(mode_q[sel_q]);
            if (cmd_comb)
                comb_d = ~comb_q;
        end
    end

    always_comb begin
        active = '0;
        match  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            active[i] = Switch_IN[i] & (mode_q[i] != TM_OFF) & (mode_q[i] <= TM_LAST);
            case (mode_q[i])
                TM_RISE: match[i] = samp_q[i] & ~hist_q[i];
                TM_FALL: match[i] = ~samp_q[i] & hist_q[i];
                TM_ANY:  match[i] = samp_q[i] ^ hist_q[i];
                TM_HIGH: match[i] = samp_q[i];
                TM_LOW:  match[i] = ~samp_q[i];
                default: match[i] = 1'b0;
            endcase
        end
        fire = comb_q ? (&(match | ~active) & |active) : |(match & active);
    end

    // Entering A_ARMED always sets blank so the first armed cycle never fires.
    always_comb begin
        arm_d   = arm_q;
        blank_d = 1'b0;
        pulse_d = 1'b0;
        chan_d  = chan_q;
        case (arm_q)
            A_IDLE: begin
                if (Arm && |active) begin
                    arm_d   = A_ARMED;
                    blank_d = 1'b1;
                end
            end
            A_ARMED: begin
                if (!blank_q && fire) begin
                    arm_d   = A_TRIG;
                    pulse_d = 1'b1;
                    chan_d  = match & active;
                end
            end
            A_TRIG: begin
                if (Arm) begin
                    arm_d   = A_ARMED;
                    blank_d = 1'b1;
                end
            end
            default: arm_d = A_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            sel_q   <= '0;
            mode_q  <= '0;
            comb_q  <= 1'b0;
            sync1_q <= '0;
            samp_q  <= '0;
            hist_q  <= '0;
            arm_q   <= A_IDLE;
            blank_q <= 1'b0;
            pulse_q <= 1'b0;
            chan_q  <= '0;
        end else begin
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            comb_q  <= comb_d;
            sync1_q <= CH_INPUT;
            samp_q  <= sync1_q;
            hist_q  <= samp_q;
            arm_q   <= arm_d;
            blank_q <= blank_d;
            pulse_q <= pulse_d;
            chan_q  <= chan_d;
        end
    end

    assign Ch_Sel        = sel_q;
    assign Trig_Mode_OUT = mode_q;
    assign Trig_Combine  = comb_q;
    assign Armed         = (arm_q == A_ARMED);
    assign Trig_Pulse    = pulse_q;
    assign Trig_Chan     = chan_q;

endmodule

// File: tb/tb_loga_trig_unit.sv
// Bench for loga_trig_unit: directed scenarios plus random traffic against a behavioural model.
module tb_loga_trig_unit;

    localparam int CH = 8;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      key_in;
    logic            key_valid;
    logic [CH-1:0]   sw;
    logic [CH-1:0]   ch_in;
    logic            arm;
    logic [CW-1:0]   ch_sel;
    logic [3*CH-1:0] trig_mode;
    logic            trig_comb;
    logic            armed;
    logic            trig_pulse;
    logic [CH-1:0]   trig_chan;

    always #5 clk = ~clk;

    loga_trig_unit #(.CH_NUM(CH)) dut (
        .CLOCK         (clk),
        .RESET         (rst_n),
        .Key_IN        (key_in),
        .Key_Valid     (key_valid),
        .Switch_IN     (sw),
        .CH_INPUT      (ch_in),
        .Arm           (arm),
        .Ch_Sel        (ch_sel),
        .Trig_Mode_OUT (trig_mode),
        .Trig_Combine  (trig_comb),
        .Armed         (armed),
        .Trig_Pulse    (trig_pulse),
        .Trig_Chan     (trig_chan)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: integers for selection/modes, a 3-deep sample history.
    int            m_sel;
    int            m_mode[CH];
    bit            m_comb;
    int            m_kst;     // 0 plain, 1 after E0, 2 after break prefix
    int            m_arm;     // 0 idle, 1 armed, 2 triggered
    bit            m_blank;
    bit            m_pulse;
    logic [CH-1:0] m_chan;
    logic [CH-1:0] q1, q2, q3;

    function automatic bit mode_hit(input int mode, input bit s, input bit p);
        case (mode)
            1: return s && !p;
            2: return !s && p;
            3: return s != p;
            4: return s;
            5: return !s;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3*CH-1:0] packed_modes();
        logic [3*CH-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[3*i +: 3] = 3'(m_mode[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_comb = 0; m_kst = 0; m_arm = 0; m_blank = 0; m_pulse = 0;
        m_chan = '0; q1 = '0; q2 = '0; q3 = '0;
        for (int i = 0; i < CH; i++) m_mode[i] = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] act, hit;
        bit fire, locked, nb, np;
        if (!rst_n) begin
            model_reset();
            return;
        end
        act = '0; hit = '0;
        for (int i = 0; i < CH; i++) begin
            act[i] = sw[i] && (m_mode[i] >= 1) && (m_mode[i] <= 5);
            hit[i] = mode_hit(m_mode[i], q2[i], q3[i]);
        end
        if (m_comb) fire = (act != '0) && ((hit & act) == act);
        else        fire = (hit & act) != '0;
        locked = (m_arm == 1);
        if (key_valid) begin
            if (m_kst == 2) begin
                m_kst = 0;
                if (key_in == 8'h72) m_sel = (m_sel + 1) % CH;
                else if (key_in == 8'h75) m_sel = (m_sel + CH - 1) % CH;
                else if (key_in == 8'h2C && !locked && sw[m_sel]) m_mode[m_sel] = (m_mode[m_sel] + 1) % 6;
                else if (key_in == 8'h21 && !locked) m_comb = !m_comb;
                else if (key_in == 8'h2D && !locked) for (int i = 0; i < CH; i++) m_mode[i] = 0;
            end else if (key_in == 8'hF0) m_kst = 2;
            else if (key_in == 8'hE0 && m_kst == 0) m_kst = 1;
            else m_kst = 0;
        end
        nb = 0; np = 0;
        if (m_arm == 0) begin
            if (arm && act != '0) begin m_arm = 1; nb = 1; end
        end else if (m_arm == 1) begin
            if (!m_blank && fire) begin m_arm = 2; np = 1; m_chan = hit & act; end
        end else begin
            if (arm) begin m_arm = 1; nb = 1; end
        end
        m_blank = nb;
        m_pulse = np;
        q3 = q2; q2 = q1; q1 = ch_in;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("ch_sel",  32'(ch_sel),     32'(m_sel));
        check("modes",   32'(trig_mode),  32'(packed_modes()));
        check("combine", 32'(trig_comb),  32'(m_comb));
        check("armed",   32'(armed),      32'(m_arm == 1));
        check("pulse",   32'(trig_pulse), 32'(m_pulse));
        check("chan",    32'(trig_chan),  32'(m_chan));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_key(input logic [7:0] b);
        key_in = b; key_valid = 1'b1;
        step();
        key_valid = 1'b0; key_in = 8'h00;
    endtask

    task automatic brk(input logic [7:0] b);
        send_key(8'hF0);
        send_key(b);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    logic [7:0] key_tbl[8];
    int         exp_steps[6];

    initial begin
        key_tbl = '{8'hF0, 8'hE0, 8'h72, 8'h75, 8'h2C, 8'h21, 8'h2D, 8'h1C};
        exp_steps = '{1, 2, 3, 4, 5, 0};
        rst_n = 1'b0; key_in = 8'h00; key_valid = 1'b0; sw = '0; ch_in = '0; arm = 1'b0;
        model_reset();
        @(negedge clk);
        idle(2);
        check("rst_sel",   32'(ch_sel), 32'd0);
        check("rst_modes", 32'(trig_mode), 32'd0);
        check("rst_pulse", 32'(trig_pulse), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Channel-select wrap in both directions; bare make codes ignored.
        brk(8'h75);
        check("sel_wrap_dn", 32'(ch_sel), 32'd7);
        send_key(8'hE0); send_key(8'hF0); send_key(8'h72);
        check("sel_wrap_up", 32'(ch_sel), 32'd0);
        send_key(8'h72);
        check("sel_make", 32'(ch_sel), 32'd0);

        // Mode cycling on channel 0, gated by the enable switch on channel 1.
        sw = 8'h01;
        for (int k = 0; k < 6; k++) begin
            brk(8'h2C);
            check("mode_cycle", 32'(trig_mode[2:0]), 32'(exp_steps[k]));
        end
        brk(8'h72);
        brk(8'h2C);
        check("mode_gated", 32'(trig_mode[5:3]), 32'd0);

        // Rising edge, OR combine.
        brk(8'h75);
        brk(8'h2C);
        idle(3);
        pulse_arm();
        check("armed_rise", 32'(armed), 32'd1);
        idle(2);
        ch_in = 8'h01;
        idle(2);
        check("rise_early", 32'(trig_pulse), 32'd0);
        idle(1);
        check("rise_pulse", 32'(trig_pulse), 32'd1);
        check("rise_chan",  32'(trig_chan), 32'h01);
        check("rise_disarm", 32'(armed), 32'd0);
        idle(1);
        check("pulse_single", 32'(trig_pulse), 32'd0);

        // AND combine: ch0 high-level, ch1 low-level.
        sw = 8'h03;
        brk(8'h2C); brk(8'h2C); brk(8'h2C);
        brk(8'h72);
        for (int k = 0; k < 5; k++) brk(8'h2C);
        brk(8'h21);
        check("and_modes", 32'(trig_mode), 32'h2C);
        ch_in = 8'h03;
        idle(4);
        pulse_arm();
        for (int k = 0; k < 5; k++) begin
            step();
            check("and_hold", 32'(trig_pulse), 32'd0);
        end

        // Configuration lockout while armed.
        brk(8'h2D);
        brk(8'h21);
        check("lock_modes", 32'(trig_mode), 32'h2C);
        check("lock_comb",  32'(trig_comb), 32'd1);
        ch_in = 8'h01;
        idle(3);
        check("and_pulse", 32'(trig_pulse), 32'd1);
        check("and_chan",  32'(trig_chan), 32'h03);
        idle(1);

        // Arm together with a live match in A_TRIG: re-arm wins, no pulse.
        pulse_arm();
        check("rearm_armed", 32'(armed), 32'd1);
        check("rearm_pulse", 32'(trig_pulse), 32'd0);
        idle(1);
        check("blank_pulse", 32'(trig_pulse), 32'd0);
        idle(1);
        check("level_fire", 32'(trig_pulse), 32'd1);

        // Reset while armed with an edge in flight.
        ch_in = 8'h03;
        idle(4);
        pulse_arm();
        idle(2);
        ch_in = 8'h01;
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_chan",  32'(trig_chan), 32'd0);
        check("rst_mode2", 32'(trig_mode), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rst_nopulse", 32'(trig_pulse), 32'd0);
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_in    = key_tbl[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) sw = CH'($urandom);
            if ($urandom_range(0, 3) == 0) ch_in = ch_in ^ (CH'(1) << $urandom_range(0, CH-1));
            arm = ($urandom_range(0, 7) == 0);
            step();
        end
        key_valid = 1'b0; arm = 1'b0; rst_n = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
